// File: rtl/bat_amateur_pkg.sv
// Shared definitions for the RAM bus masters: state encoding, RAM_RW levels and default widths.
package bat_amateur_pkg;

    localparam int DEFAULT_ADDRESS_WIDTH = 16;
    localparam int DEFAULT_DATA_WIDTH    = 16;

    localparam logic RAM_RW_READ  = 1'b1;
    localparam logic RAM_RW_WRITE = 1'b0;

    // Wide enough for HALT_SETTLE up to 15 and RD_LATENCY up to 7
    localparam int CNT_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_REQ    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_SEND   = 3'd4,
        ST_FINISH = 3'd5
    } dump_state_t;

endpackage

// File: rtl/ram_dump_reader.sv
// Halts the CPU, reads RAM words START_ADDR..END_ADDR over the shared bus and streams them
// out on a valid/ready port as (address, data) pairs.
module ram_dump_reader
    import bat_amateur_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int RD_LATENCY    = 1,
    parameter int HALT_SETTLE   = 2
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     START,
    input  logic                     ABORT,
    input  logic [ADDRESS_WIDTH-1:0] START_ADDR,
    input  logic [ADDRESS_WIDTH-1:0] END_ADDR,
    output logic                     HALT,
    output logic                     BUS_OWN,
    output logic                     RAM_EN,
    output logic                     RAM_RW,
    output logic [ADDRESS_WIDTH-1:0] ADDRESS_BUS,
    input  logic [DATA_WIDTH-1:0]    DATA_BUS,
    output logic [DATA_WIDTH-1:0]    OUT_DATA,
    output logic [ADDRESS_WIDTH-1:0] OUT_ADDR,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic                     BUSY,
    output logic                     DONE
);

    // A zero settle time still spends one cycle in SETTLE
    localparam int SETTLE_CYCLES = (HALT_SETTLE < 1) ? 1 : HALT_SETTLE;
    localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] WAIT_LOAD   = CNT_WIDTH'(RD_LATENCY - 1);

    dump_state_t              state;
    logic [CNT_WIDTH-1:0]     cnt;
    logic [ADDRESS_WIDTH-1:0] cur;
    logic [ADDRESS_WIDTH-1:0] last;

    logic empty_start;
    logic abort_now;
    logic last_sent;
    logic go_finish;

    // The block only ever reads, so RAM_RW is tied to the read level.
    assign RAM_RW = RAM_RW_READ;

    assign empty_start = (state == ST_IDLE) && START && (END_ADDR < START_ADDR);
    assign abort_now   = ABORT && (state inside {ST_SETTLE, ST_REQ, ST_WAIT, ST_SEND});
    // Testing cur==last before incrementing lets END_ADDR = all-ones terminate without wrapping
    assign last_sent   = (state == ST_SEND) && OUT_READY && (cur == last);
    assign go_finish   = empty_start || abort_now || last_sent;

    // NOTE: sequential state uses non-blocking assignments only, so every branch below
    // sees the pre-edge values of state, cnt and cur regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cur         <= '0;
            last        <= '0;
            HALT        <= 1'b0;
            BUS_OWN     <= 1'b0;
            RAM_EN      <= 1'b0;
            ADDRESS_BUS <= '0;
            OUT_DATA    <= '0;
            OUT_ADDR    <= '0;
            OUT_VALID   <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (go_finish) begin
                // Abort takes priority over a same-cycle handshake; the word still counts as sent
                state       <= ST_FINISH;
                HALT        <= 1'b0;
                BUS_OWN     <= 1'b0;
                RAM_EN      <= 1'b0;
                ADDRESS_BUS <= '0;
                OUT_VALID   <= 1'b0;
                BUSY        <= 1'b1;
                DONE        <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (START) begin
                            cur   <= START_ADDR;
                            last  <= END_ADDR;
                            cnt   <= SETTLE_LOAD;
                            HALT  <= 1'b1;
                            BUSY  <= 1'b1;
                            state <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt == '0) begin
                            BUS_OWN     <= 1'b1;
                            RAM_EN      <= 1'b1;
                            ADDRESS_BUS <= cur;
                            state       <= ST_REQ;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_REQ: begin
                        cnt   <= WAIT_LOAD;
                        state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (cnt == '0) begin
                            OUT_DATA  <= DATA_BUS;
                            OUT_ADDR  <= cur;
                            OUT_VALID <= 1'b1;
                            RAM_EN    <= 1'b0;
                            state     <= ST_SEND;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_SEND: begin
                        if (OUT_READY) begin
                            OUT_VALID   <= 1'b0;
                            cur         <= cur + 1'b1;
                            ADDRESS_BUS <= cur + 1'b1;
                            RAM_EN      <= 1'b1;
                            state       <= ST_REQ;
                        end
                    end
                    ST_FINISH: begin
                        BUSY  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ram_dump_reader.sv
// Self-checking bench for ram_dump_reader: a latency-modelled RAM, directed corner cases and
// randomized dumps compared against an expected (address, data) list built from the RAM contents.
module tb_ram_dump_reader;

    localparam int AW         = 16;
    localparam int DW         = 16;
    localparam int RD_LAT     = 3;
    localparam int HS         = 2;
    localparam int SETTLE_CYC = (HS < 1) ? 1 : HS;
    localparam int BUDGET     = 4000;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          START;
    logic          ABORT;
    logic [AW-1:0] START_ADDR;
    logic [AW-1:0] END_ADDR;
    logic          HALT;
    logic          BUS_OWN;
    logic          RAM_EN;
    logic          RAM_RW;
    logic [AW-1:0] ADDRESS_BUS;
    logic [DW-1:0] DATA_BUS;
    logic [DW-1:0] OUT_DATA;
    logic [AW-1:0] OUT_ADDR;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic          BUSY;
    logic          DONE;

    int checks = 0;
    int errors = 0;

    ram_dump_reader #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .RD_LATENCY   (RD_LAT),
        .HALT_SETTLE  (HS)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .ABORT      (ABORT),
        .START_ADDR (START_ADDR),
        .END_ADDR   (END_ADDR),
        .HALT       (HALT),
        .BUS_OWN    (BUS_OWN),
        .RAM_EN     (RAM_EN),
        .RAM_RW     (RAM_RW),
        .ADDRESS_BUS(ADDRESS_BUS),
        .DATA_BUS   (DATA_BUS),
        .OUT_DATA   (OUT_DATA),
        .OUT_ADDR   (OUT_ADDR),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    always #5 CLK = ~CLK;

    // RAM model: data for an address appears RD_LAT cycles after it is presented with RAM_EN.
    // NOTE: the storage array is never reset; contents are loaded by the bench before use.
    logic [DW-1:0] mem [0:65535];
    logic [AW-1:0] pipe_a [RD_LAT];
    logic          pipe_v [RD_LAT];

    always @(posedge CLK) begin
        pipe_a[0] <= ADDRESS_BUS;
        pipe_v[0] <= RAM_EN;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_v[i] <= pipe_v[i-1];
        end
    end

    assign DATA_BUS = pipe_v[RD_LAT-1] ? mem[pipe_a[RD_LAT-1]] : 16'hDEAD;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_halt"},      HALT,        0);
        check({tag, "_bus_own"},   BUS_OWN,     0);
        check({tag, "_ram_en"},    RAM_EN,      0);
        check({tag, "_ram_rw"},    RAM_RW,      1);
        check({tag, "_addr_bus"},  ADDRESS_BUS, 0);
        check({tag, "_out_data"},  OUT_DATA,    0);
        check({tag, "_out_addr"},  OUT_ADDR,    0);
        check({tag, "_out_valid"}, OUT_VALID,   0);
        check({tag, "_busy"},      BUSY,        0);
        check({tag, "_done"},      DONE,        0);
    endtask

    // One dump from s to e. ready_pct: chance of READY per cycle; stall_idx: word held off
    // for 5 cycles; abort_idx: word during whose SEND ABORT is raised (-1 = none).
    task automatic run_dump(input logic [AW-1:0] s, input logic [AW-1:0] e,
                            input int ready_pct, input int stall_idx, input int abort_idx);
        logic [AW-1:0] exp_addr [$];
        logic [DW-1:0] exp_data [$];
        int n, got, reads, done_cnt, halt_rise, req_rise, stall_left, cycle;
        logic halt_prev, en_prev, valid_prev, ready_prev, aborting, abort_fired;
        logic abort_with_ready, seen_halt, finished;
        logic [AW-1:0] held_addr;
        logic [DW-1:0] held_data;

        exp_addr.delete();
        exp_data.delete();
        for (int a = int'(s); a <= int'(e); a++) begin
            exp_addr.push_back(AW'(a));
            exp_data.push_back(mem[a]);
        end
        n = exp_addr.size();
        got = 0; reads = 0; done_cnt = 0; halt_rise = 0; req_rise = 0; stall_left = 5;
        halt_prev = 0; en_prev = 0; valid_prev = 0; ready_prev = 0;
        aborting = 0; abort_fired = 0; abort_with_ready = 0; seen_halt = 0; finished = 0;
        held_addr = '0; held_data = '0;

        @(negedge CLK);
        START_ADDR = s;
        END_ADDR   = e;
        START      = 1'b1;
        OUT_READY  = 1'b0;
        @(negedge CLK);
        START = 1'b0;

        for (cycle = 1; cycle <= BUDGET && !finished; cycle++) begin
            check("ram_rw_read", RAM_RW, 1);
            if (!BUS_OWN) begin
                check("unowned_ram_en", RAM_EN, 0);
                check("unowned_addr", ADDRESS_BUS, 0);
            end
            if (cycle == 1 && n == 0) check("empty_done_latency", DONE, 1);
            if (HALT && !halt_prev) begin
                halt_rise = cycle;
                seen_halt = 1;
            end
            if (halt_prev && !HALT) check("halt_drop_only_at_done", DONE, 1);
            if (RAM_EN && !en_prev) begin
                if (reads == 0) check("settle_cycles", cycle - halt_rise, SETTLE_CYC);
                check("read_addr", ADDRESS_BUS, 32'(int'(s) + reads));
                check("halt_during_read", HALT, 1);
                reads++;
                req_rise = cycle;
            end
            if (OUT_VALID && !valid_prev) check("word_latency", cycle - req_rise, RD_LAT + 1);
            if (OUT_VALID && valid_prev && !ready_prev) begin
                check("stall_addr_stable", OUT_ADDR, held_addr);
                check("stall_data_stable", OUT_DATA, held_data);
                check("stall_no_req", RAM_EN, 0);
            end
            if (aborting) begin
                check("abort_done", DONE, 1);
                check("abort_valid_low", OUT_VALID, 0);
                ABORT    = 1'b0;
                aborting = 0;
            end
            if (DONE) begin
                done_cnt++;
                check("done_halt_low", HALT, 0);
                check("done_bus_released", BUS_OWN, 0);
                check("done_valid_low", OUT_VALID, 0);
            end

            if (done_cnt > 0 && !DONE) begin
                check("idle_after_done", BUSY, 0);
                finished = 1;
            end else begin
                if (OUT_VALID && got == stall_idx && stall_left > 0) begin
                    OUT_READY = 1'b0;
                    stall_left--;
                end else begin
                    OUT_READY = ($urandom_range(99) < 32'(ready_pct));
                end
                if (OUT_VALID && got == abort_idx && !abort_fired) begin
                    ABORT            = 1'b1;
                    aborting         = 1;
                    abort_fired      = 1;
                    abort_with_ready = OUT_READY;
                end
                if (OUT_VALID && OUT_READY) begin
                    if (exp_addr.size() > 0) begin
                        check("word_addr", OUT_ADDR, exp_addr.pop_front());
                        check("word_data", OUT_DATA, exp_data.pop_front());
                    end else begin
                        check("unexpected_word", 1, 0);
                    end
                    got++;
                end
                halt_prev  = HALT;
                en_prev    = RAM_EN;
                valid_prev = OUT_VALID;
                ready_prev = OUT_READY;
                held_addr  = OUT_ADDR;
                held_data  = OUT_DATA;
                @(negedge CLK);
            end
        end

        OUT_READY = 1'b0;
        ABORT     = 1'b0;
        if (!finished) check("timeout", 0, 1);
        check("done_count", done_cnt, 1);
        check("halt_seen", seen_halt, (n > 0) ? 1 : 0);
        if (abort_idx >= 0 && abort_idx < n) begin
            check("abort_fired", abort_fired, 1);
            check("abort_word_count", got, abort_idx + (abort_with_ready ? 1 : 0));
            check("abort_read_count", reads, abort_idx + 1);
        end else begin
            check("word_count", got, n);
            check("read_count", reads, n);
        end
    endtask

    initial begin
        logic [AW-1:0] rs, re;
        int len, ab, st;

        for (int i = 0; i < 65536; i++) mem[i] = DW'($urandom);
        RESET = 1'b1; START = 1'b0; ABORT = 1'b0; OUT_READY = 1'b0;
        START_ADDR = '0; END_ADDR = '0;
        repeat (3) @(negedge CLK);
        check_reset_values("reset");
        RESET = 1'b0;

        // ABORT while idle must not start anything
        @(negedge CLK);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        check("idle_abort_busy", BUSY, 0);
        check("idle_abort_done", DONE, 0);

        // Basic three-word dump with known contents
        mem[16'h0010] = 16'd5;
        mem[16'h0011] = 16'd0;
        mem[16'h0012] = 16'd1;
        run_dump(16'h0010, 16'h0012, 100, -1, -1);

        // Backpressure on the word from 0x11
        run_dump(16'h0010, 16'h0012, 100, 1, -1);

        // Empty range
        run_dump(16'h0012, 16'h0010, 100, -1, -1);

        // Top of the address space
        run_dump(16'hFFFE, 16'hFFFF, 100, -1, -1);

        // Abort during SEND of the 2nd of 4 words, READY high in the same cycle
        run_dump(16'h0040, 16'h0043, 100, -1, 1);

        // Randomized dumps
        for (int r = 0; r < 10; r++) begin
            rs  = AW'($urandom_range(0, 300));
            len = $urandom_range(1, 6);
            re  = ($urandom_range(7) == 0) ? rs - 1'b1 : AW'(int'(rs) + len - 1);
            ab  = ($urandom_range(3) == 0) ? $urandom_range(0, len - 1) : -1;
            st  = $urandom_range(0, len - 1);
            run_dump(rs, re, $urandom_range(30, 100), st, ab);
        end

        // Reset in the middle of the second word's WAIT
        mem[16'h0080] = 16'h1234;
        @(negedge CLK);
        START_ADDR = 16'h0080;
        END_ADDR   = 16'h0081;
        START      = 1'b1;
        OUT_READY  = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int i = 0; i < 100 && !OUT_VALID; i++) @(negedge CLK);
        check("rst_test_first_word", OUT_VALID, 1);
        for (int i = 0; i < 100 && !RAM_EN; i++) @(negedge CLK);
        check("rst_test_second_req", RAM_EN, 1);
        @(negedge CLK);
        check("rst_test_out_data_loaded", OUT_DATA, 16'h1234);
        RESET = 1'b1;
        OUT_READY = 1'b0;
        @(negedge CLK);
        check_reset_values("mid_wait_reset");
        RESET = 1'b0;
        run_dump(16'h0080, 16'h0081, 100, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
